uart_rx_word_buffer: RTL

Receive-side stage between `UARTModule` and `core`. It consumes the single-cycle `wb_flag`/`wb_data` byte strobes, assembles each group of four bytes into one little-endian 32-bit word, and queues the words in a small FIFO. The core pops words with a valid/ready handshake. It also discards stalled partial words by timeout and reports overflow and framing errors as sticky flags.

---
 rtl/uart_pkg.sv | 14 +
 rtl/sync_fifo.sv | 75 +++++++
 rtl/uart_rx_word_buffer.sv | 133 +++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART word-buffer types and widths.
// Byte/word geometry and RX buffer FSM states.
package uart_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int BYTE_W         = 8;
  localparam int WORD_W         = BYTES_PER_WORD * BYTE_W;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } rxbuf_state_t;

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO.
// Ports: clock, reset (async low), push/push_data, pop, flush,
//   head_data, count, full, empty.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  input  logic                       flush,
  output logic [WIDTH-1:0]           head_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, wr_d;
  logic [AW-1:0]    rd_q, rd_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             do_push;
  logic             do_pop;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == (AW+1)'(DEPTH));
  assign count = cnt_q;

  // Empty FIFO presents zero rather than stale storage.
  assign head_data = empty ? '0 : mem_q[rd_q];

  assign do_pop  = pop && !empty && !flush;
  // Full is fine when the head leaves in the same cycle.
  assign do_push = push && !flush && (!full || do_pop);

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) wr_d = wr_q + AW'(1);
      if (do_pop)  rd_d = rd_q + AW'(1);
      unique case (1'b1)
        do_push && !do_pop: cnt_d = cnt_q + (AW+1)'(1);
        do_pop && !do_push: cnt_d = cnt_q - (AW+1)'(1);
        default:            cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_q] <= push_data;
  end

endmodule

// File: rtl/uart_rx_word_buffer.sv
// Packs UART RX bytes into little-endian 32-bit words and queues them.
// Ports: clock, reset, wb_flag/wb_data in; word_data/valid/ready, count, byte_index, overflow, frame_error.
module uart_rx_word_buffer
  import uart_pkg::*;
#(
  parameter int DEPTH          = 4,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     wb_flag,
  input  logic [7:0]               wb_data,
  input  logic                     clear,
  output logic [31:0]              word_data,
  output logic                     word_valid,
  input  logic                     word_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic [1:0]               byte_index,
  output logic                     overflow,
  output logic                     frame_error
);

  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  rxbuf_state_t      state_q, state_d;
  logic [1:0]        idx_q, idx_d;
  logic [WORD_W-1:0] lane_q, lane_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic              ovf_q, ovf_d;
  logic              fe_q, fe_d;

  logic              fifo_full;
  logic              fifo_empty;
  logic              pop;
  logic              push;
  logic              timeout_hit;
  logic [WORD_W-1:0] push_word;

  assign pop        = word_ready && !fifo_empty && !clear;
  assign push_word  = {wb_data, lane_q[23:0]};
  // Timer holds k-1 at the k-th idle edge; the discard edge is TIMEOUT_CYCLES-1.
  assign timeout_hit = (timer_q == TW'(TIMEOUT_CYCLES - 2));

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    lane_d  = lane_q;
    timer_d = timer_q;
    ovf_d   = ovf_q;
    fe_d    = fe_q;
    push    = 1'b0;
    if (clear) begin
      state_d = IDLE;
      idx_d   = '0;
      timer_d = '0;
      ovf_d   = 1'b0;
      fe_d    = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (wb_flag) begin
            lane_d[7:0] = wb_data;
            idx_d       = 2'd1;
            timer_d     = '0;
            state_d     = COLLECT;
          end
        end
        COLLECT: begin
          if (wb_flag) begin
            timer_d = '0;
            if (idx_q == 2'd3) begin
              if (!fifo_full || pop) push  = 1'b1;
              else                   ovf_d = 1'b1;
              idx_d   = '0;
              state_d = IDLE;
            end else begin
              lane_d[{idx_q, 3'b000} +: BYTE_W] = wb_data;
              idx_d = idx_q + 2'd1;
            end
          end else if (timeout_hit) begin
            idx_d   = '0;
            timer_d = '0;
            fe_d    = 1'b1;
            state_d = IDLE;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      lane_q  <= '0;
      timer_q <= '0;
      ovf_q   <= 1'b0;
      fe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      lane_q  <= lane_d;
      timer_q <= timer_d;
      ovf_q   <= ovf_d;
      fe_q    <= fe_d;
    end
  end

  sync_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data (push_word),
    .pop       (pop),
    .flush     (clear),
    .head_data (word_data),
    .count     (count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign word_valid  = !fifo_empty;
  assign byte_index  = idx_q;
  assign overflow    = ovf_q;
  assign frame_error = fe_q;

endmodule
